// File: rtl/fanout_pipe_chain.sv
// fanout_pipe_chain: elastic valid/ready delay chain with a single-stage
// bypass mode and a bank of round-robin tap capture registers that copy every
// accepted input word.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Valid, once raised, holds its word until that
// edge. Ready may depend combinationally on the downstream ready; the only
// such path is out_ready -> in_ready.
module fanout_pipe_chain #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 5,
  parameter int FANOUT = 10,
  localparam int OW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(FANOUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    bypass,
  output logic                    mode_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [OW-1:0]           occupancy,
  input  logic                    tap_clr,
  output logic [FANOUT*WIDTH-1:0] tap_data,
  output logic [FANOUT-1:0]       tap_valid,
  output logic [PW-1:0]           tap_ptr
);

  // Stage 0 is the source capture register; stage DEPTH-1 drives the output
  // in chain mode.
  logic [DEPTH-1:0] stg_v;
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             in_fire;
  logic             out_fire;
  logic [OW-1:0]    occ_q;

  logic [WIDTH-1:0] tap_q [FANOUT];
  logic [FANOUT-1:0] tap_valid_q;
  logic [PW-1:0]    tap_ptr_q;

  // Output selection: bypass reads stage 0, chain reads the last stage.
  always_comb begin
    out_valid = mode_q ? stg_v[0] : stg_v[DEPTH-1];
    out_data  = mode_q ? stg_d[0] : stg_d[DEPTH-1];
  end

  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~stg_v[0] | adv[0];
  assign in_fire   = in_valid & in_ready;
  assign occupancy = occ_q;

  // Per-stage advance: a stage moves when some stage after it is empty, or
  // the consumer takes the word off the end. Scanning from the output end
  // with a running "hole seen" flag keeps the logic free of feedback.
  always_comb begin
    logic hole;
    adv  = '0;
    hole = 1'b0;
    if (mode_q) begin
      adv[0] = stg_v[0] & out_ready;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        adv[i] = stg_v[i] & (hole | out_ready);
        hole   = hole | ~stg_v[i];
      end
    end
  end

  // Stage registers: stage 0 captures in_data, later stages take the word
  // from their predecessor. Data is left in place when a stage empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v <= '0;
      for (int i = 0; i < DEPTH; i++) stg_d[i] <= '0;
    end else begin
      if (in_fire) begin
        stg_v[0] <= 1'b1;
        stg_d[0] <= in_data;
      end else if (adv[0]) begin
        stg_v[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1] && !mode_q) begin
          stg_v[i] <= 1'b1;
          stg_d[i] <= stg_d[i-1];
        end else if (adv[i]) begin
          stg_v[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy tracks words inside the chain; simultaneous in/out cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (in_fire && !out_fire) begin
      occ_q <= occ_q + OW'(1);
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  // Mode register: only switches when the chain is empty and idle, so a
  // mode change can never strand or reorder a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (occ_q == '0 && !in_fire) begin
      mode_q <= bypass;
    end
  end

  // Tap capture: each accepted word lands in the slot named by tap_ptr. A
  // clear wipes all valid flags except the slot being written this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_valid_q <= '0;
      for (int k = 0; k < FANOUT; k++) tap_q[k] <= '0;
    end else begin
      for (int k = 0; k < FANOUT; k++) begin
        if (in_fire && tap_ptr_q == PW'(k)) begin
          tap_q[k]       <= in_data;
          tap_valid_q[k] <= 1'b1;
        end else if (tap_clr) begin
          tap_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Tap pointer: round-robin over FANOUT slots, untouched by tap_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_ptr_q <= '0;
    end else if (in_fire) begin
      tap_ptr_q <= (tap_ptr_q == PW'(FANOUT - 1)) ? '0 : tap_ptr_q + PW'(1);
    end
  end

  // Flatten the tap bank onto the packed output bus.
  always_comb begin
    tap_data = '0;
    for (int k = 0; k < FANOUT; k++) tap_data[k*WIDTH +: WIDTH] = tap_q[k];
  end

  assign tap_valid = tap_valid_q;
  assign tap_ptr   = tap_ptr_q;

endmodule

// File: tb/tb_fanout_pipe_chain.sv
// Directed bench for fanout_pipe_chain (WIDTH=8, DEPTH=5, FANOUT=10).
module tb_fanout_pipe_chain;

  localparam int W = 8;
  localparam int D = 5;
  localparam int F = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          bypass;
  logic          mode_q;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    occupancy;
  logic          tap_clr;
  logic [F*W-1:0] tap_data;
  logic [F-1:0]  tap_valid;
  logic [3:0]    tap_ptr;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tap_exp [F] = '{8'h1A, 8'h1B, 8'h12, 8'h13, 8'h14,
                                8'h15, 8'h16, 8'h17, 8'h18, 8'h19};

  fanout_pipe_chain #(.WIDTH(W), .DEPTH(D), .FANOUT(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bypass    (bypass),
    .mode_q    (mode_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .tap_clr   (tap_clr),
    .tap_data  (tap_data),
    .tap_valid (tap_valid),
    .tap_ptr   (tap_ptr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    bypass    = 1'b0;
    out_ready = 1'b0;
    tap_clr   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int acc;
    int em;
    int peak;
    int budget;
    logic [W-1:0] e;

    // Reset state
    idle_inputs();
    rst = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_mode", mode_q, 0);
    check("rst_tap_valid", tap_valid, 0);
    check("rst_tap_ptr", tap_ptr, 0);
    check("rst_tap_data_zero", 32'(tap_data == '0), 1);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    step();

    // Steady flow: 0x01..0x0A back-to-back, 5-cycle latency, no gaps
    out_ready = 1'b1;
    peak = 0;
    for (int c = 0; c < 15; c++) begin
      if (c < 10) begin
        in_valid = 1'b1;
        in_data  = W'(c + 1);
        #1;
        check("flow_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      acc = (c + 1 < 10) ? c + 1 : 10;
      em  = (c >= 5) ? c - 4 : 0;
      check("flow_occupancy", occupancy, acc - em);
      if (int'(occupancy) > peak) peak = int'(occupancy);
      check("flow_out_valid", out_valid, (c >= 4 && c <= 13) ? 1 : 0);
      if (c >= 4 && c <= 13) check("flow_out_data", out_data, c - 3);
    end
    check("flow_peak_occ", peak, 5);

    // Backpressure: 5 of 7 accepted, then all drain in order
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h21 + c);
      exp_q.push_back(in_data);
      #1;
      check("bp_in_ready_acc", in_ready, 1);
      step();
    end
    in_valid = 1'b1;
    in_data  = 8'h26;
    #1;
    check("bp_in_ready_full", in_ready, 0);
    check("bp_occ_full", occupancy, 5);
    check("bp_out_valid", out_valid, 1);
    step();
    check("bp_in_ready_hold", in_ready, 0);
    check("bp_occ_hold", occupancy, 5);
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (j == 0) begin
        exp_q.push_back(8'h26);
      end else if (j == 1) begin
        in_data = 8'h27;
        exp_q.push_back(8'h27);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (j < 2) check("bp_in_ready_rel", in_ready, 1);
      check("bp_drain_valid", out_valid, 1);
      e = exp_q.pop_front();
      check("bp_drain_data", out_data, e);
      step();
    end
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_occ", occupancy, 0);

    // Bypass switch while occupancy=3
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h31 + c);
      step();
    end
    in_valid = 1'b0;
    bypass   = 1'b1;
    check("byp_occ3", occupancy, 3);
    step();
    check("byp_mode_held", mode_q, 0);
    out_ready = 1'b1;
    budget = 0;
    while (occupancy != 0 && budget < 20) begin
      check("byp_mode_draining", mode_q, 0);
      step();
      budget++;
    end
    check("byp_drained", occupancy, 0);
    check("byp_mode_at_empty", mode_q, 0);
    step();
    check("byp_mode_on", mode_q, 1);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    check("byp_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("byp_a5_valid", out_valid, 1);
    check("byp_a5_data", out_data, 8'hA5);
    check("byp_a5_occ", occupancy, 1);
    step();
    check("byp_a5_gone", out_valid, 0);
    check("byp_occ0", occupancy, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB1;
    step();
    in_data = 8'hB2;
    #1;
    check("byp_bp_in_ready", in_ready, 0);
    check("byp_bp_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("byp_bp_valid", out_valid, 1);
    check("byp_bp_data", out_data, 8'hB1);
    check("byp_bp_occ_max", occupancy, 1);
    bypass    = 1'b0;
    out_ready = 1'b1;
    step();
    check("byp_exit_occ", occupancy, 0);
    check("byp_exit_mode_held", mode_q, 1);
    step();
    check("byp_exit_mode", mode_q, 0);

    // Tap wrap: 12 words from a clean reset
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h10 + c);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < F; k++) check("tap_wrap_data", tap_data[k*W +: W], tap_exp[k]);
    check("tap_wrap_valid", tap_valid, 10'h3FF);
    check("tap_wrap_ptr", tap_ptr, 2);

    // tap_clr colliding with a write at tap_ptr=4
    in_valid = 1'b1;
    in_data  = 8'h20;
    step();
    in_data = 8'h21;
    step();
    check("clr_pre_ptr", tap_ptr, 4);
    in_data = 8'h3C;
    tap_clr = 1'b1;
    step();
    in_valid = 1'b0;
    tap_clr  = 1'b0;
    check("clr_valid", tap_valid, 10'h010);
    check("clr_tap4", tap_data[4*W +: W], 8'h3C);
    check("clr_tap3_kept", tap_data[3*W +: W], 8'h21);
    check("clr_tap0_kept", tap_data[0 +: W], 8'h1A);
    check("clr_ptr", tap_ptr, 5);
    tap_clr = 1'b1;
    step();
    tap_clr = 1'b0;
    check("clr_only_valid", tap_valid, 0);
    check("clr_only_ptr", tap_ptr, 5);
    for (int c = 0; c < 6; c++) step();
    check("pre_arst_drained", occupancy, 0);

    // Asynchronous reset mid-stream with occupancy=4
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h41 + c);
      step();
    end
    in_valid = 1'b0;
    check("arst_pre_occ", occupancy, 4);
    check("arst_pre_tap_valid", tap_valid, 10'h1E0);
    check("arst_pre_ptr", tap_ptr, 9);
    #3;
    rst = 1'b1;
    #1;
    check("arst_occ", occupancy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_tap_valid", tap_valid, 0);
    check("arst_tap_ptr", tap_ptr, 0);
    check("arst_tap_data_zero", 32'(tap_data == '0), 1);
    #2;
    rst = 1'b0;
    step();
    check("arst_in_ready", in_ready, 1);
    check("arst_post_occ", occupancy, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("arst_no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fanout_pipe_chain.md
Name: fanout_pipe_chain

Overview:
- Parametrised elastic delay chain for timing-repair characterisation.
- A source capture register feeds a DEPTH-stage valid/ready pipeline of WIDTH-bit words.
- Every accepted word is also copied into one of FANOUT round-robin tap registers, which forms a high-fanout load on the source.
- A bypass mode collapses the chain to single-stage latency.
- Sits as a hierarchical child below the register-bank top and is clocked with all other sequential cells.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 5, pipeline stages between the source register and the output (>=1).
- FANOUT, 10, number of tap capture registers (>=2).

Ports:
- clk  input  1  sole clock; all flops on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  chain can accept a word this cycle.
- in_data  input  WIDTH  producer word.
- bypass  input  1  requested mode: 1 = single-stage path.
- mode_q  output  1  mode currently in effect.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  output word.
- occupancy  output  $clog2(DEPTH+1)  count of valid pipeline stages.
- tap_clr  input  1  clear all tap_valid bits.
- tap_data  output  FANOUT*WIDTH  tap k occupies bits [k*WIDTH +: WIDTH].
- tap_valid  output  FANOUT  per-tap written flag.
- tap_ptr  output  $clog2(FANOUT)  next tap slot to be written.

Behaviour:
- Reset (asynchronous, effective immediately on rst=1, regardless of clk):
  - all stage valids 0; all stage data 0
  - out_valid 0, out_data 0, occupancy 0, mode_q 0
  - tap_data all 0, tap_valid 0, tap_ptr 0
  - in_ready is 1 once rst deasserts
  - reset mid-transfer drops all in-flight words; nothing is replayed.
- Definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - Stage 0 is the source capture register.
- Chain mode (mode_q=0):
  - Stage 0 through stage DEPTH-1 are valid/data registers; out_valid/out_data come from stage DEPTH-1.
  - Stage i (i < DEPTH-1) advances into stage i+1 when stage i+1 is empty or moving on the same cycle.
  - The last stage moves on out_fire.
  - Ready propagates combinationally back along the chain, so a full chain with out_ready=1 sustains 1 word/cycle.
  - Latency with no backpressure: a word accepted on edge n appears on out_data after edge n+DEPTH-1, i.e. DEPTH cycles.
  - in_ready = stage 0 empty or stage 0 advancing.
  - No bubble is inserted by backpressure. Data order is strictly preserved.
- Bypass mode (mode_q=1):
  - Only stage 0 is used; out_valid/out_data come from stage 0.
  - Latency is 1 cycle.
  - Stages 1..DEPTH-1 stay invalid.
- Mode switching:
  - mode_q loads bypass only on an edge where occupancy==0 and in_fire==0.
  - Otherwise mode_q holds, so a mode change never reorders or drops words.
- occupancy:
  - Increments on in_fire only; decrements on out_fire only; unchanged when both fire.
  - Never exceeds DEPTH in chain mode or 1 in bypass mode.
- Taps:
  - On each in_fire, in_data is written into tap[tap_ptr] and tap_valid[tap_ptr] is set.
  - tap_ptr then increments, wrapping FANOUT-1 -> 0.
  - Older taps are overwritten on wrap.
- tap_clr:
  - Clears all tap_valid bits. tap_data is unchanged.
  - If tap_clr and in_fire occur together, the slot written that cycle ends with tap_valid=1 and all other slots end at 0.
  - tap_ptr is not affected by tap_clr.
- Combinational path: out_data is register-sourced; the only combinational input-to-output path is out_ready -> in_ready.

Test Plan:
- Reset/steady flow:
  - Stimulus: DEPTH=5, WIDTH=8, out_ready=1; push 0x01..0x0A back-to-back.
  - Required: in_ready=1 throughout; 0x01 appears 5 cycles after acceptance; outputs arrive 0x01..0x0A with no gaps; occupancy peaks at 5.
- Backpressure:
  - Stimulus: hold out_ready=0 while pushing 7 words.
  - Required: first 5 accepted; in_ready=0 after the 5th; occupancy=5. Release out_ready; all 7 emerge in order, one per cycle.
- Bypass switch:
  - Stimulus: assert bypass while occupancy=3.
  - Required: mode_q stays 0 until the chain drains to 0. Afterwards, word 0xA5 appears 1 cycle after acceptance; occupancy never exceeds 1.
- Tap wrap:
  - Stimulus: FANOUT=10; push 12 words 0x10..0x1B.
  - Required: tap[0]=0x1A, tap[1]=0x1B, tap[2..9]=0x12..0x19; tap_valid=all 1s; tap_ptr=2.
- tap_clr collision:
  - Stimulus: tap_clr=1 in the same cycle as an in_fire of 0x3C with tap_ptr=4.
  - Required: tap_valid=0x010; tap[4]=0x3C; tap_ptr=5.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with occupancy=4.
  - Required: outputs zero immediately, before the next edge. After release, in_ready=1 and occupancy=0; no stale words emerge.
